// File: rtl/cordic_req_arbiter.sv
`timescale 1ns/1ps
// cordic_req_arbiter: round-robin front end that shares one CORDIC calculator
// among NUM_REQ requesters, with a watchdog on hung operations.
module cordic_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [4*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_x,
  input  logic [WIDTH*NUM_REQ-1:0] req_y,
  input  logic [WIDTH*NUM_REQ-1:0] req_z,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     cordic_enable,
  output logic [3:0]               cordic_operation,
  output logic [WIDTH-1:0]         cordic_x,
  output logic [WIDTH-1:0]         cordic_y,
  output logic [WIDTH-1:0]         cordic_z,
  input  logic [WIDTH-1:0]         cordic_result,
  input  logic                     cordic_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand_p;
  int unsigned        cand;
  logic               any_req;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [TW-1:0]      timer;
  logic [WIDTH-1:0]   result_q;
  logic               error_q;
  logic [3:0]         sel_op;
  logic [WIDTH-1:0]   sel_x;
  logic [WIDTH-1:0]   sel_y;
  logic [WIDTH-1:0]   sel_z;

  // Round-robin search: first pending request starting just above ptr.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    cand    = 0;
    cand_p  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand   = (32'(ptr) + i) % NUM_REQ;
      cand_p = PW'(cand);
      if (!any_req && req_valid[cand_p]) begin
        any_req = 1'b1;
        win     = cand_p;
      end
    end
  end

  // Operand mux for the current winner and one-hot decode of grant/winner.
  always_comb begin
    sel_op    = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_z     = '0;
    gnt_oh    = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == win) begin
        sel_op = req_op[4*i +: 4];
        sel_x  = req_x[WIDTH*i +: WIDTH];
        sel_y  = req_y[WIDTH*i +: WIDTH];
        sel_z  = req_z[WIDTH*i +: WIDTH];
      end
      gnt_oh[i]    = (PW'(i) == gnt);
      req_ready[i] = (state == IDLE) && any_req && !rst && (PW'(i) == win);
    end
  end

  // Sequencer FSM with registered calculator-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= PW'(NUM_REQ - 1);
      gnt              <= '0;
      timer            <= '0;
      result_q         <= '0;
      error_q          <= 1'b0;
      busy             <= 1'b0;
      cordic_enable    <= 1'b0;
      cordic_operation <= '0;
      cordic_x         <= '0;
      cordic_y         <= '0;
      cordic_z         <= '0;
      rsp_valid        <= '0;
    end else begin
      cordic_enable <= 1'b0;
      rsp_valid     <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt              <= win;
            cordic_operation <= sel_op;
            cordic_x         <= sel_x;
            cordic_y         <= sel_y;
            cordic_z         <= sel_z;
            cordic_enable    <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done is checked first so it wins over a coincident timeout
          if (cordic_done) begin
            result_q  <= cordic_result;
            error_q   <= 1'b0;
            rsp_valid <= gnt_oh;
            state     <= RESP;
          end else if (timer >= TW'(TIMEOUT - 1)) begin
            result_q  <= '0;
            error_q   <= 1'b1;
            rsp_valid <= gnt_oh;
            state     <= RESP;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          ptr   <= gnt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_result = result_q;
  assign rsp_error  = error_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
`timescale 1ns/1ps
// Directed bench for cordic_req_arbiter; the calculator side is driven by hand.
module tb_cordic_req_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 20;
  localparam logic [3:0] OP_SIN  = 4'd0;
  localparam logic [3:0] OP_MULT = 4'd10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [3:0]     op_a [N];
  logic [W-1:0]   x_a [N];
  logic [W-1:0]   y_a [N];
  logic [W-1:0]   z_a [N];
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_x, req_y, req_z;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_error, busy, cordic_enable;
  logic [3:0]     cordic_operation;
  logic [W-1:0]   cordic_x, cordic_y, cordic_z, cordic_result;
  logic           cordic_done;

  int checks = 0;
  int errors = 0;

  assign req_op = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_x  = {x_a[3], x_a[2], x_a[1], x_a[0]};
  assign req_y  = {y_a[3], y_a[2], y_a[1], y_a[0]};
  assign req_z  = {z_a[3], z_a[2], z_a[1], z_a[0]};

  always #5 clk = ~clk;

  cordic_req_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .busy(busy), .cordic_enable(cordic_enable), .cordic_operation(cordic_operation),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z),
    .cordic_result(cordic_result), .cordic_done(cordic_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // One full transaction from an IDLE cycle; done arrives after d WAIT cycles.
  task automatic txn(input logic [3:0] vld, input int g, input int d, input logic [W-1:0] res);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    req_valid = vld;
    #1;
    chk("req_ready", req_ready, oh);
    step;
    chk("issue_enable", cordic_enable, 1);
    chk("issue_op", cordic_operation, op_a[g]);
    chk("issue_x", cordic_x, x_a[g]);
    chk("issue_y", cordic_y, y_a[g]);
    chk("issue_z", cordic_z, z_a[g]);
    chk("issue_ready_low", req_ready, 0);
    step;
    chk("wait_enable_low", cordic_enable, 0);
    chk("wait_busy", busy, 1);
    for (int k = 0; k < d; k++) begin
      chk("wait_no_rsp", rsp_valid, 0);
      step;
    end
    cordic_done = 1'b1;
    cordic_result = res;
    step;
    cordic_done = 1'b0;
    cordic_result = 32'hDEAD_BEEF;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_result", rsp_result, res);
    chk("rsp_error", rsp_error, 0);
    step;
    chk("idle_rsp_low", rsp_valid, 0);
    chk("idle_busy_low", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    cordic_done = 1'b0;
    cordic_result = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 4'(i + 1);
      x_a[i]  = 32'h1000_0000 + 32'(i);
      y_a[i]  = 32'h2000_0000 + 32'(i);
      z_a[i]  = 32'h3000_0000 + 32'(i);
    end
    step;
    step;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", cordic_enable, 0);
    chk("rst_op", cordic_operation, 0);
    chk("rst_xyz", {cordic_x, cordic_y} | 64'(cordic_z), 0);
    rst = 1'b0;

    // Round-robin order after reset
    txn(4'b0111, 0, 1, 32'h1111_0000);
    txn(4'b0111, 1, 2, 32'h2222_0000);
    txn(4'b0111, 2, 0, 32'h3333_0000);
    txn(4'b1001, 3, 0, 32'h4444_0000);
    txn(4'b1001, 0, 1, 32'h5555_0000);

    // MULT from requester 3
    op_a[3] = OP_MULT;
    x_a[3]  = 32'h0001_8000;
    y_a[3]  = 32'h0000_0000;
    z_a[3]  = 32'h0002_0000;
    txn(4'b1000, 3, 5, 32'h0003_0000);

    // SIN from requester 0
    op_a[0] = OP_SIN;
    x_a[0]  = 32'h0000_0000;
    y_a[0]  = 32'h0000_0000;
    z_a[0]  = 32'h0000_C90F;
    txn(4'b0001, 0, 3, 32'h0000_B505);

    // done arriving in the same cycle the timeout would fire
    txn(4'b1000, 3, TO - 1, 32'h0000_7FFF);

    // Watchdog: done never raised
    req_valid = 4'b0010;
    cordic_result = 32'hDEAD_BEEF;
    #1;
    chk("wd_ready", req_ready, 4'b0010);
    step;
    chk("wd_enable", cordic_enable, 1);
    req_valid = '0;
    for (int k = 1; k <= TO; k++) begin
      step;
      chk("wd_no_early_rsp", rsp_valid, 0);
    end
    step;
    chk("wd_rsp_valid", rsp_valid, 4'b0010);
    chk("wd_rsp_error", rsp_error, 1);
    chk("wd_rsp_result", rsp_result, 0);
    step;
    chk("wd_idle_busy", busy, 0);
    txn(4'b0100, 2, 0, 32'h1234_5678);

    // Reset pulsed during WAIT
    req_valid = 4'b0001;
    #1;
    chk("rm_ready", req_ready, 4'b0001);
    step;
    req_valid = '0;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    chk("rm_req_ready", req_ready, 0);
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_rsp_result", rsp_result, 0);
    chk("rm_rsp_error", rsp_error, 0);
    chk("rm_busy", busy, 0);
    chk("rm_enable", cordic_enable, 0);
    chk("rm_op", cordic_operation, 0);
    chk("rm_z", cordic_z, 0);
    cordic_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("rm_no_rsp", rsp_valid, 0);
      chk("rm_idle_done_ignored", busy, 0);
    end
    cordic_done = 1'b0;
    txn(4'b1111, 0, 2, 32'h0F0F_0F0F);

    // Stale done in IDLE and ISSUE, real done after 10 WAIT cycles
    req_valid = 4'b0100;
    cordic_done = 1'b1;
    cordic_result = 32'hBAD0_0001;
    #1;
    chk("sd_ready", req_ready, 4'b0100);
    step;
    chk("sd_enable", cordic_enable, 1);
    req_valid = '0;
    step;
    cordic_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("sd_no_rsp", rsp_valid, 0);
      step;
    end
    cordic_done = 1'b1;
    cordic_result = 32'h0ABC_DEF0;
    step;
    cordic_done = 1'b0;
    chk("sd_rsp_valid", rsp_valid, 4'b0100);
    chk("sd_rsp_result", rsp_result, 32'h0ABC_DEF0);
    chk("sd_rsp_error", rsp_error, 0);
    step;
    chk("sd_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
